bcd_to_binary: RTL and testbench

Sequential converter from packed BCD digits to an unsigned binary value. It is the inverse of the team's combinational binary-to-BCD path. It turns operator-entered decimal values (alarm thresholds, e.g. heart-rate limits keyed as hundreds/tens/ones) back into binary for comparison logic. It uses iterative reverse double-dabble (shift right, subtract 3), one bit per clock, under a start/busy/done handshake.

---
 rtl/bcd_to_binary.sv | 131 +++++++++++++
 tb/tb_bcd_to_binary.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
//   Sequential packed-BCD to unsigned binary converter.
//   It uses reverse double-dabble and retires one result bit per clock.
//   Each step shifts {bcd_reg, bin_reg} right by one bit. Every BCD nibble that
//   is then >= 8 has 3 subtracted from it. After OUT_W steps bin_reg holds the
//   value. Anything left in bcd_reg means the input did not fit in OUT_W bits.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   conversion request, honoured only in IDLE
//   bcd_in   in   4*DIGITS packed digits {..., tens, ones}, sampled when accepted
//   bin_out  out  OUT_W result, held until the next done-producing transition
//   busy     out  high while iterating (CONV)
//   done     out  one-cycle pulse, bin_out/err valid
//   err      out  invalid digit or overflow, held with bin_out
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [OUT_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                   state;
  logic [BCD_W-1:0]         bcd_reg;
  logic [OUT_W-1:0]         bin_reg;
  logic [CNT_W-1:0]         cnt;

  logic [BCD_W+OUT_W-1:0]   shifted;
  logic [BCD_W-1:0]         bcd_next;
  logic [OUT_W-1:0]         bin_next;
  logic                     last_step;

  // Subtract 3 from every nibble that reached 8 or more after the shift.
  // Each nibble is corrected on its own, so no borrow crosses a digit boundary.
  function automatic logic [BCD_W-1:0] dabble_fix(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      nib = b[4*i +: 4];
      if (nib >= 4'd8) nib = nib - 4'd3;
      r[4*i +: 4] = nib;
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign shifted   = {bcd_reg, bin_reg} >> 1;
  assign bcd_next  = dabble_fix(shifted[BCD_W+OUT_W-1:OUT_W]);
  assign bin_next  = shifted[OUT_W-1:0];
  assign last_step = (cnt == CNT_W'(OUT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (has_bad_digit(bcd_in)) begin
              // Malformed entry: report right away without iterating.
              bin_out <= '0;
              err     <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              bcd_reg <= bcd_in;
              bin_reg <= '0;
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= CONV;
            end
          end
        end
        CONV: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_next;
          if (last_step) begin
            // A leftover BCD value means the input exceeded 2^OUT_W-1.
            err     <= (bcd_next != '0);
            bin_out <= (bcd_next != '0) ? '0 : bin_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary
//   Scoreboard bench for bcd_to_binary (DIGITS=3, OUT_W=8).
//   Each request pushes its expected result, latency and busy length onto
//   exp_q. The matching entry is popped when done appears.
module tb_bcd_to_binary;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic [7:0]  bin_out;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] bin;
    logic       err;
    int         lat;
    int         bcyc;
  } exp_t;

  exp_t exp_q[$];

  bcd_to_binary #(.DIGITS(3), .OUT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .bin_out(bin_out),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: decode the digits, then range-check the value.
  function automatic exp_t model(input logic [11:0] b);
    exp_t e;
    int   v;
    if (b[11:8] > 4'd9 || b[7:4] > 4'd9 || b[3:0] > 4'd9) begin
      e.bin = 8'h00; e.err = 1'b1; e.lat = 1; e.bcyc = 0;
    end else begin
      v = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
      e.lat = 9; e.bcyc = 8;
      if (v > 255) begin
        e.bin = 8'h00; e.err = 1'b1;
      end else begin
        e.bin = 8'(v); e.err = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic send(input logic [11:0] b);
    bcd_in = b;
    start  = 1'b1;
    exp_q.push_back(model(b));
  endtask

  // Steps one clock at a time until done, with a bounded wait.
  // lat counts the edges from the accepting edge to the first cycle with done high.
  task automatic wait_done(input logic drop_start, input logic toggle,
                           output int lat, output int bcyc,
                           output logic both, output logic moved);
    logic [7:0] b0;
    logic       e0;
    b0 = bin_out; e0 = err;
    lat = 0; bcyc = 0; both = 1'b0; moved = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      lat++;
      if (drop_start) start = 1'b0;
      if (busy && done) both = 1'b1;
      if (done) break;
      if (busy) bcyc++;
      if (bin_out !== b0 || err !== e0) moved = 1'b1;
      if (toggle) bcd_in = 12'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bcd_in = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bin_out, busy, done, err} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got bin=%h busy=%b done=%b err=%b, want all 0",
               bin_out, busy, done, err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_convert(input logic [11:0] b);
    int   lat, bcyc;
    logic both, moved;
    exp_t e;
    send(b);
    wait_done(1'b1, 1'b0, lat, bcyc, both, moved);
    e = exp_q.pop_front();
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL latency[%h]: got %0d, want %0d", b, lat, e.lat);
    end
    checks++;
    if (bcyc != e.bcyc) begin
      errors++;
      $display("FAIL busy_len[%h]: got %0d, want %0d", b, bcyc, e.bcyc);
    end
    checks++;
    if (both !== 1'b0) begin
      errors++;
      $display("FAIL busy_done_overlap[%h]: got 1, want 0", b);
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL result_hold[%h]: bin_out/err changed before done", b);
    end
    checks++;
    if (bin_out !== e.bin || err !== e.err) begin
      errors++;
      $display("FAIL result[%h]: got bin=%h err=%b, want bin=%h err=%b",
               b, bin_out, err, e.bin, e.err);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || bin_out !== e.bin || err !== e.err) begin
      errors++;
      $display("FAIL done_pulse[%h]: got done=%b bin=%h err=%b, want done=0 bin=%h err=%b",
               b, done, bin_out, err, e.bin, e.err);
    end
  endtask

  task automatic test_back_to_back();
    int   lat, bcyc;
    logic both, moved;
    exp_t e;
    // start stays high the whole time and bcd_in is scrambled mid-conversion.
    send(12'h123);
    wait_done(1'b0, 1'b1, lat, bcyc, both, moved);
    e = exp_q.pop_front();
    checks++;
    if (lat != e.lat || bin_out !== e.bin || err !== e.err) begin
      errors++;
      $display("FAIL held_start_first: got lat=%0d bin=%h err=%b, want lat=%0d bin=%h err=%b",
               lat, bin_out, err, e.lat, e.bin, e.err);
    end
    bcd_in = 12'h050;
    exp_q.push_back(model(12'h050));
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_ignores_start: got done=%b busy=%b, want 0 0", done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reaccept_after_done: got busy=%b, want 1", busy);
    end
    wait_done(1'b1, 1'b0, lat, bcyc, both, moved);
    e = exp_q.pop_front();
    checks++;
    if (lat != e.lat - 1 || bin_out !== e.bin || err !== e.err) begin
      errors++;
      $display("FAIL held_start_second: got lat=%0d bin=%h err=%b, want lat=%0d bin=%h err=%b",
               lat, bin_out, err, e.lat - 1, e.bin, e.err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    send(12'h100);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got busy=%b, want 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bin_out, busy, done, err} !== 11'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got bin=%h busy=%b done=%b err=%b, want all 0",
               bin_out, busy, done, err);
    end
    rst = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_conv: got busy/done activity after reset, want none");
    end
    test_convert(12'h100);
  endtask

  initial begin
    test_reset();
    test_convert(12'h255);
    test_convert(12'h123);
    test_convert(12'h000);
    test_convert(12'h099);
    test_convert(12'h256);
    test_convert(12'h299);
    test_convert(12'h0A3);
    test_convert(12'h042);
    test_convert(12'h09F);
    test_convert(12'h199);
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
